paced_drain: RTL and testbench

Elastic buffer for the consumer end of a stream. It accepts words over a ready/valid handshake with backpressure and releases exactly one word per `tick` strobe from a fixed-rate sink, such as a DAC or serializer that cannot stall. If the buffer is empty when a tick arrives, a sticky `underflow` flag is set, and the block re-primes before it resumes output.

---
 rtl/stream_pkg.sv | 9 +
 rtl/ring_store.sv | 44 ++++
 rtl/paced_drain.sv | 91 +++++++++
 tb/tb_paced_drain.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types for stream consumer blocks
package stream_pkg;

    typedef enum logic {
        PRIMING = 1'b0,
        RUNNING = 1'b1
    } drain_state_t;

endpackage

// File: rtl/ring_store.sv
// rtl/ring_store.sv - circular word storage with wrapping read/write pointers
module ring_store #(
    parameter int DATA_SIZE  = 16,
    parameter int FIFO_DEPTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] wdata,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        rd;
    logic [PW-1:0]        wr;

    // Explicit wrap so non-power-of-two depths never index past the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd <= '0;
            wr <= '0;
        end else begin
            if (push) begin
                wr <= (wr == LAST) ? '0 : wr + 1'b1;
            end
            if (pop) begin
                rd <= (rd == LAST) ? '0 : rd + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr] <= wdata;
        end
    end

    assign rdata = mem[rd];

endmodule

// File: rtl/paced_drain.sv
// rtl/paced_drain.sv - elastic buffer releasing one word per sink tick
module paced_drain
    import stream_pkg::*;
#(
    parameter int DATA_SIZE   = 16,
    parameter int FIFO_DEPTH  = 5,
    parameter int PRIME_LEVEL = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_SIZE-1:0]              in_data,
    input  logic                              tick,
    output logic [DATA_SIZE-1:0]              out_data,
    output logic                              out_strobe,
    output logic                              underflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] PRIME_THOLD = LW'(PRIME_LEVEL);

    drain_state_t         state;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DATA_SIZE-1:0] rdata;

    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == RUNNING) && tick && !empty;

    ring_store #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ring_store (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A tick on an empty buffer re-primes; a same-cycle push is stored, never bypassed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= PRIMING;
            out_data   <= '0;
            out_strobe <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            out_strobe <= pop;
            if (pop) begin
                out_data <= rdata;
            end
            case (state)
                PRIMING: begin
                    if (level >= PRIME_THOLD) begin
                        state <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (tick && empty) begin
                        underflow <= 1'b1;
                        state     <= PRIMING;
                    end
                end
                default: state <= PRIMING;
            endcase
        end
    end

endmodule

// File: tb/tb_paced_drain.sv
// tb/tb_paced_drain.sv - randomized and directed bench for paced_drain against a queue model
module tb_paced_drain;
    import stream_pkg::*;

    localparam int DATA_SIZE   = 16;
    localparam int FIFO_DEPTH  = 5;
    localparam int PRIME_LEVEL = 3;
    localparam int LW          = $clog2(FIFO_DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] in_data;
    logic                 tick;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_strobe;
    logic                 underflow;
    logic [LW-1:0]        level;

    always #5 clk = ~clk;

    paced_drain #(
        .DATA_SIZE   (DATA_SIZE),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .PRIME_LEVEL (PRIME_LEVEL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .tick       (tick),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .underflow  (underflow),
        .level      (level)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: words held in arrival order, plus the sink-side view.
    logic [DATA_SIZE-1:0] m_q[$];
    bit                   m_run;
    bit                   m_uf;
    bit                   m_strobe;
    logic [DATA_SIZE-1:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_strobe", 32'(out_strobe), 32'(m_strobe));
        check("underflow", 32'(underflow), 32'(m_uf));
        check("level", 32'(level), 32'(m_q.size()));
        check("state", 32'(dut.state), m_run ? 32'(RUNNING) : 32'(PRIMING));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick     = 1'b0;
        in_data  = '0;
        @(posedge clk);
        #1;
        m_q.delete();
        m_run    = 1'b0;
        m_uf     = 1'b0;
        m_strobe = 1'b0;
        m_data   = '0;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
    endtask

    task automatic step(input bit v, input logic [DATA_SIZE-1:0] d, input bit t);
        bit accept;
        bit was_run;
        int fill;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        tick     = t;
        #1;
        fill   = m_q.size();
        accept = v && (fill < FIFO_DEPTH);
        check("in_ready", 32'(in_ready), 32'(fill < FIFO_DEPTH));
        was_run  = m_run;
        m_strobe = 1'b0;
        if (!was_run) begin
            if (fill >= PRIME_LEVEL) m_run = 1'b1;
        end else if (t) begin
            if (fill > 0) begin
                m_data   = m_q.pop_front();
                m_strobe = 1'b1;
            end else begin
                m_uf  = 1'b1;
                m_run = 1'b0;
            end
        end
        if (accept) m_q.push_back(d);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tick     = 1'b0;

        // Priming threshold
        do_reset();
        step(1, 16'h0011, 1);
        step(1, 16'h0022, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        check("prime_level2", 32'(level), 32'd2);
        check("prime_no_strobe", 32'(out_strobe), 32'd0);
        step(1, 16'h0033, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        check("prime_first_word", 32'(out_data), 32'h0011);
        check("prime_first_strobe", 32'(out_strobe), 32'd1);

        // Fill to full, then tick with in_valid on a full buffer
        do_reset();
        for (int i = 0; i < FIFO_DEPTH; i++) step(1, 16'h0200 + 16'(i), 0);
        step(0, 16'h0000, 0);
        check("full_level", 32'(level), 32'd5);
        check("full_in_ready", 32'(in_ready), 32'd0);
        step(1, 16'hAAAA, 1);
        check("full_pop_level", 32'(level), 32'd4);
        check("full_pop_ready", 32'(in_ready), 32'd1);

        // Underflow and re-priming
        do_reset();
        step(1, 16'h0011, 0);
        step(1, 16'h0022, 0);
        step(1, 16'h0033, 0);
        step(0, 16'h0000, 0);
        for (int i = 0; i < 4; i++) step(0, 16'h0000, 1);
        check("uf_flag", 32'(underflow), 32'd1);
        check("uf_hold", 32'(out_data), 32'h0033);
        for (int i = 0; i < 3; i++) step(0, 16'h0000, 1);
        for (int i = 0; i < 3; i++) step(1, 16'h0300 + 16'(i), 1);
        for (int i = 0; i < 4; i++) step(0, 16'h0000, 1);

        // Pointer wrap with continuous streaming
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 16'h0100 + 16'(i), i >= 3);
        for (int i = 0; i < 6; i++) step(0, 16'h0000, 1);

        // Same-cycle push into an empty running buffer
        do_reset();
        step(1, 16'h0011, 0);
        step(1, 16'h0022, 0);
        step(1, 16'h0033, 0);
        step(0, 16'h0000, 0);
        for (int i = 0; i < 3; i++) step(0, 16'h0000, 1);
        step(1, 16'hBEEF, 1);
        check("same_uf", 32'(underflow), 32'd1);
        check("same_level", 32'(level), 32'd1);
        step(1, 16'h0044, 0);
        step(1, 16'h0055, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 1);
        check("same_beef_out", 32'(out_data), 32'hBEEF);

        // Randomized traffic with periodic mid-stream resets
        for (int seg = 0; seg < 6; seg++) begin
            int pv;
            int pt;
            pv = $urandom_range(20, 95);
            pt = $urandom_range(20, 95);
            for (int i = 0; i < 250; i++) begin
                step($urandom_range(0, 99) < pv, 16'($urandom), $urandom_range(0, 99) < pt);
            end
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
